// File: rtl/updown_counter_pkg.sv
// Shared constants and types for the programmable up/down counter.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents:
//   MODE_UP / MODE_DOWN  : encodings of the m (direction) input
//   BND_WRAP / BND_SAT   : encodings of the sat (boundary mode) input
//   ev_t                 : event reported by the next-value calculator
package updown_counter_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  localparam logic BND_WRAP  = 1'b0;
  localparam logic BND_SAT   = 1'b1;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_WRAP = 2'd1,
    EV_SAT  = 2'd2,
    EV_OOR  = 2'd3
  } ev_t;

endpackage

// File: rtl/updown_next_calc.sv
// Combinational next-count calculator for one step inside the range 0..limit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever inputs are stable.
//
// Ports:
//   count_i      : current count, assumed <= limit_i
//   s_i          : effective step (N+1 bits), already clamped to limit_i+1
//   limit_i      : inclusive upper bound of the range
//   m_i          : direction (MODE_UP / MODE_DOWN)
//   sat_i        : boundary mode (BND_WRAP / BND_SAT)
//   next_count_o : count after applying the step
//   ev_o         : EV_NONE, EV_WRAP or EV_SAT describing the update
module updown_next_calc
  import updown_counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] count_i,
  input  logic [N:0]   s_i,
  input  logic [N-1:0] limit_i,
  input  logic         m_i,
  input  logic         sat_i,
  output logic [N-1:0] next_count_o,
  output ev_t          ev_o
);

  // Everything is widened by one bit so count+s and count+limit+1 never overflow.
  logic [N:0] cnt_ext;
  logic [N:0] lim_ext;
  logic [N:0] lim1;
  logic [N:0] sum;

  assign cnt_ext = {1'b0, count_i};
  assign lim_ext = {1'b0, limit_i};
  assign lim1    = lim_ext + {{N{1'b0}}, 1'b1};
  assign sum     = cnt_ext + s_i;

  always_comb begin
    next_count_o = count_i;
    ev_o         = EV_NONE;
    if (s_i != '0) begin
      if (m_i == MODE_UP) begin
        if (sum <= lim_ext) begin
          next_count_o = N'(sum);
        end else if (sat_i == BND_SAT) begin
          next_count_o = limit_i;
          ev_o         = EV_SAT;
        end else begin
          // s <= limit+1 keeps the wrapped result inside 0..limit.
          next_count_o = N'(sum - lim1);
          ev_o         = EV_WRAP;
        end
      end else begin
        if (s_i <= cnt_ext) begin
          next_count_o = N'(cnt_ext - s_i);
        end else if (sat_i == BND_SAT) begin
          next_count_o = '0;
          ev_o         = EV_SAT;
        end else begin
          next_count_o = N'(cnt_ext + lim1 - s_i);
          ev_o         = EV_WRAP;
        end
      end
    end
  end

endmodule

// File: rtl/n_bit_programmable_updown_counter.sv
// Programmable up/down counter with load, range limit, wrap/saturate and event pulses.
// Latency: 1 cycle from inputs to count and pulses; at_max/at_min are combinational on count.
// Backpressure: none; accepts a command every cycle.
//
// Ports:
//   clk, reset_n          : clock and synchronous active-low reset
//   en, m, sat, step      : count enable, direction, boundary mode, step size
//   limit                 : inclusive upper bound of the count range
//   load, load_val        : synchronous parallel load (clamped to limit)
//   count                 : registered counter value
//   wrapped, sat_hit, oor : registered one-cycle event pulses (mutually exclusive)
//   at_max, at_min        : count == limit, count == 0
module n_bit_programmable_updown_counter
  import updown_counter_pkg::*;
#(
  parameter int             N       = 8,
  parameter int             STEP_W  = 4,
  parameter logic [N-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              m,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      limit,
  input  logic              load,
  input  logic [N-1:0]      load_val,
  output logic [N-1:0]      count,
  output logic              wrapped,
  output logic              sat_hit,
  output logic              oor,
  output logic              at_max,
  output logic              at_min
);

  logic [N-1:0] count_q, count_d;
  logic         wrapped_q, wrapped_d;
  logic         sat_hit_q, sat_hit_d;
  logic         oor_q, oor_d;

  logic [N:0]   step_ext;
  logic [N:0]   lim1;
  logic [N:0]   s_eff;
  logic [N-1:0] calc_next;
  ev_t          calc_ev;

  assign step_ext = {{(N + 1 - STEP_W){1'b0}}, step};
  assign lim1     = {1'b0, limit} + {{N{1'b0}}, 1'b1};
  // Larger steps than the range size would just wrap around more than once.
  assign s_eff    = (step_ext > lim1) ? lim1 : step_ext;

  updown_next_calc #(
    .N (N)
  ) u_next_calc (
    .count_i      (count_q),
    .s_i          (s_eff),
    .limit_i      (limit),
    .m_i          (m),
    .sat_i        (sat),
    .next_count_o (calc_next),
    .ev_o         (calc_ev)
  );

  // Priority: load > out-of-range recovery > step > hold.
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    sat_hit_d = 1'b0;
    oor_d     = 1'b0;
    if (load) begin
      if (load_val > limit) begin
        count_d = limit;
        oor_d   = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (count_q > limit) begin
      // Limit moved below the current count (or RST_VAL is above it).
      count_d = limit;
      oor_d   = 1'b1;
    end else if (en) begin
      count_d   = calc_next;
      wrapped_d = (calc_ev == EV_WRAP);
      sat_hit_d = (calc_ev == EV_SAT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q   <= RST_VAL;
      wrapped_q <= 1'b0;
      sat_hit_q <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
      sat_hit_q <= sat_hit_d;
      oor_q     <= oor_d;
    end
  end

  assign count   = count_q;
  assign wrapped = wrapped_q;
  assign sat_hit = sat_hit_q;
  assign oor     = oor_q;
  assign at_max  = (count_q == limit);
  assign at_min  = (count_q == '0);

endmodule

// File: doc/n_bit_programmable_updown_counter.md
Name: n_bit_programmable_updown_counter

Overview:
Parametrised up/down counter and successor to the basic N-bit synchronous up/down counter. Adds the following features:
- count enable
- programmable step size
- programmable upper limit, so the count range is 0..limit
- synchronous parallel load
- per-cycle selection of wrap or saturate at the range boundaries
- registered event pulses

Used as a general-purpose timer, address or credit counter inside datapath blocks.

Parameters:
N, 8, counter width in bits (N >= 2)
STEP_W, 4, width of step input (STEP_W <= N)
RST_VAL, 0, count value after reset (N bits)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
en  input  1  count enable; 1 = apply one step this cycle
m  input  1  mode; 0 = count up, 1 = count down
sat  input  1  boundary mode; 0 = wrap, 1 = saturate
step  input  STEP_W  increment/decrement amount; 0 = hold
limit  input  N  inclusive upper bound of count range
load  input  1  synchronous parallel load strobe
load_val  input  N  value loaded when load = 1
count  output  N  registered counter value
wrapped  output  1  registered 1-cycle pulse: last update wrapped
sat_hit  output  1  registered 1-cycle pulse: last update was clamped
oor  output  1  registered 1-cycle pulse: out-of-range recovery happened
at_max  output  1  combinational, count == limit
at_min  output  1  combinational, count == 0

Behaviour:
- All state updates on the rising edge of clk. Latency is 1 cycle from inputs to count and pulses.
- Priority per edge, highest first: reset_n=0 > load > out-of-range recovery > en step > hold.
- Reset (reset_n=0 at edge):
  - count = RST_VAL; wrapped = sat_hit = oor = 0.
  - Reset asserted mid-sequence discards any pending load or step in that cycle.
- Load:
  - count = min(load_val, limit).
  - oor = 1 if load_val > limit, else 0.
  - wrapped = sat_hit = 0.
  - en, m, step and sat are ignored that cycle.
- Out-of-range recovery (no load, count > limit, e.g. limit was lowered):
  - count = limit; oor = 1.
  - Applies regardless of en, m and sat; no step applied that cycle.
- Step (no load, count <= limit, en=1):
  - All arithmetic is done in N+1 bits.
  - Effective step s = min(step, limit+1). step=0 means hold with no pulses.
  - Up (m=0), when count + s <= limit: count = count + s.
  - Up, when count + s > limit:
    - sat=1: count = limit, sat_hit = 1.
    - sat=0: count = count + s - (limit+1), wrapped = 1.
  - Down (m=1), when s <= count: count = count - s.
  - Down, when s > count:
    - sat=1: count = 0, sat_hit = 1.
    - sat=0: count = count - s + (limit+1), wrapped = 1.
  - sat_hit = 1 also when already at the boundary (at_max going up, or at_min going down) with sat=1 and s>0; count is unchanged.
- Hold (en=0, no load, in range): count unchanged; all pulses = 0.
- Pulse exclusivity: at most one of wrapped, sat_hit, oor is 1 in any cycle. Each pulse deasserts on the following edge unless retriggered.
- limit = 0:
  - count is pinned at 0.
  - Any up or down step with s>0 produces wrapped=1 (sat=0) or sat_hit=1 (sat=1).
- limit = 2^N - 1 with sat=0: behaves as a plain modulo-2^N counter.
- RST_VAL > limit after reset: the first active edge performs recovery (oor=1).

Decomposition:
- Package updown_counter_pkg holds:
  - MODE_UP = 1'b0, MODE_DOWN = 1'b1
  - BND_WRAP = 1'b0, BND_SAT = 1'b1
  - an event-type enum: EV_NONE, EV_WRAP, EV_SAT, EV_OOR
- One combinational sub-module, updown_next_calc. It takes count, s, limit, m and sat, and returns next_count plus the event type.
- The top module holds the registers, priority mux, load clamp, recovery logic and pulse decode.

Test Plan:
- N=8, reset_n=0 for 2 cycles, then release with en=0 -> count=0, all pulses 0, at_min=1.
- limit=9, step=3, m=0, sat=0, en=1 from 0 -> count sequence 3, 6, 9, 2 (wrapped=1 on the cycle count becomes 2), then 5.
- limit=9, step=4, m=1, sat=1, from count=6 -> 2, then 0 with sat_hit=1, then 0 with sat_hit=1 again; at_min=1.
- load=1, load_val=200, limit=100 -> count=100, oor=1. Next cycle with en=0 -> oor=0, count=100.
- count=50, then limit lowered to 20 with en=0 -> next edge count=20, oor=1. With load=1 and en=1 in the same cycle as reset_n=0 -> count=RST_VAL, no pulses.
- limit=255, step=15 (STEP_W=4), m=0, sat=0 from count=250 -> count=9, wrapped=1. Then step=0 -> count holds at 9, no pulses.
